// File: rtl/uart_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_reg_pkg
//  Description : Shared command codes, frame FSM state encoding and the
//                address range helper for the UART register bank.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_reg_pkg;

    localparam logic [7:0] CMD_NOP = 8'h00;
    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;

    typedef enum logic [2:0] {
        S_CMD     = 3'd0,
        S_ADDR    = 3'd1,
        S_WDATA   = 3'd2,
        S_TX_REQ  = 3'd3,
        S_TX_WAIT = 3'd4
    } state_t;

    // True when an 8-bit address selects one of the implemented registers.
    function automatic logic addr_in_range(input logic [7:0] addr, input int unsigned n_regs);
        return (32'(addr) < n_regs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_core.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_core
//  Description : Register array with one write port and one asynchronous read
//                port. Out-of-range addresses never write and read as zero.
//                Also flattens the array onto regs_o.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_bank_core #(
    parameter int N_REGS = 4,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [7:0]                 addr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [7:0]                 raddr,
    output logic [DATA_W-1:0]          rdata,
    output logic                       waddr_ok,
    output logic                       raddr_ok,
    output logic [N_REGS*DATA_W-1:0]   regs_o
);
    import uart_reg_pkg::*;

    logic [DATA_W-1:0] r_regs [N_REGS];

    assign waddr_ok = addr_in_range(addr, N_REGS);
    assign raddr_ok = addr_in_range(raddr, N_REGS);

    // Register storage: cleared by reset, one entry loaded per in-range write.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int k = 0; k < N_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (we && waddr_ok) begin
            for (int k = 0; k < N_REGS; k++) begin
                if (addr == 8'(k)) begin
                    r_regs[k] <= wdata;
                end
            end
        end
    end

    // Read mux: unmatched (out-of-range) addresses fall through to zero.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (raddr == 8'(k)) begin
                rdata = r_regs[k];
            end
        end
    end

    for (genvar k = 0; k < N_REGS; k++) begin : g_flat
        assign regs_o[k*DATA_W +: DATA_W] = r_regs[k];
    end

endmodule
`default_nettype wire

// File: rtl/uart_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : uart_reg_bank
//  Description : Decodes NOP / WRITE / READ frames from a UART byte stream,
//                updates the register bank and returns read data byte by
//                byte through a tx_wr_o / tx_done_i handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_reg_bank #(
    parameter int N_REGS = 4,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_done_i,
    input  logic [7:0]                 data_i,
    input  logic                       tx_done_i,
    output logic                       tx_wr_o,
    output logic [7:0]                 tx_data_o,
    output logic [N_REGS*DATA_W-1:0]   regs_o,
    output logic                       main_fsm_en_o,
    output logic                       err_o,
    output logic                       busy_o
);
    import uart_reg_pkg::*;

    localparam int              NB     = DATA_W / 8;
    localparam int              CNT_W  = $clog2(NB + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NB - 1);

    state_t            r_state,    w_state_nxt;
    logic              r_wr_flag,  w_wr_flag_nxt;
    logic [7:0]        r_addr,     w_addr_nxt;
    logic [CNT_W-1:0]  r_byte_cnt, w_byte_cnt_nxt;
    logic [DATA_W-1:0] r_wr_shift, w_wr_shift_nxt;
    logic [DATA_W-1:0] r_tx_shift, w_tx_shift_nxt;
    logic              r_err,      w_err_nxt;

    logic              w_we;
    logic [DATA_W-1:0] w_wr_word;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_waddr_ok;
    logic              w_raddr_ok;

    // Incoming byte appended to the partial write word; on the last byte this
    // is the full value committed to the bank.
    assign w_wr_word = DATA_W'({r_wr_shift, data_i});

    reg_bank_core #(
        .N_REGS (N_REGS),
        .DATA_W (DATA_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (w_we),
        .addr     (r_addr),
        .wdata    (w_wr_word),
        .raddr    (data_i),
        .rdata    (w_rd_data),
        .waddr_ok (w_waddr_ok),
        .raddr_ok (w_raddr_ok),
        .regs_o   (regs_o)
    );

    // Frame decoder: next state, datapath updates, write strobe and errors.
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_flag_nxt  = r_wr_flag;
        w_addr_nxt     = r_addr;
        w_byte_cnt_nxt = r_byte_cnt;
        w_wr_shift_nxt = r_wr_shift;
        w_tx_shift_nxt = r_tx_shift;
        w_err_nxt      = 1'b0;
        w_we           = 1'b0;

        case (r_state)
            S_CMD: begin
                if (rx_done_i) begin
                    case (data_i)
                        CMD_WR: begin
                            w_state_nxt   = S_ADDR;
                            w_wr_flag_nxt = 1'b1;
                        end
                        CMD_RD: begin
                            w_state_nxt   = S_ADDR;
                            w_wr_flag_nxt = 1'b0;
                        end
                        CMD_NOP: begin
                            w_state_nxt = S_CMD;
                        end
                        default: begin
                            w_err_nxt = 1'b1;
                        end
                    endcase
                end
            end

            S_ADDR: begin
                if (rx_done_i) begin
                    w_addr_nxt     = data_i;
                    w_byte_cnt_nxt = '0;
                    if (r_wr_flag) begin
                        w_state_nxt = S_WDATA;
                    end else begin
                        // Snapshot taken now; rx is locked out until the reply ends.
                        w_tx_shift_nxt = w_rd_data;
                        w_err_nxt      = ~w_raddr_ok;
                        w_state_nxt    = S_TX_REQ;
                    end
                end
            end

            S_WDATA: begin
                if (rx_done_i) begin
                    w_wr_shift_nxt = w_wr_word;
                    w_byte_cnt_nxt = r_byte_cnt + 1'b1;
                    if (r_byte_cnt == C_LAST) begin
                        w_we           = 1'b1;
                        w_err_nxt      = ~w_waddr_ok;
                        w_byte_cnt_nxt = '0;
                        w_state_nxt    = S_CMD;
                    end
                end
            end

            S_TX_REQ: begin
                w_err_nxt   = rx_done_i;
                w_state_nxt = S_TX_WAIT;
            end

            S_TX_WAIT: begin
                w_err_nxt = rx_done_i;
                if (tx_done_i) begin
                    // Shifting on every byte leaves the shifter at zero after the reply.
                    w_tx_shift_nxt = r_tx_shift << 8;
                    if (r_byte_cnt == C_LAST) begin
                        w_byte_cnt_nxt = '0;
                        w_state_nxt    = S_CMD;
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + 1'b1;
                        w_state_nxt    = S_TX_REQ;
                    end
                end
            end

            default: begin
                w_state_nxt = S_CMD;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= S_CMD;
            r_wr_flag  <= 1'b0;
            r_addr     <= '0;
            r_byte_cnt <= '0;
            r_wr_shift <= '0;
            r_tx_shift <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_flag  <= w_wr_flag_nxt;
            r_addr     <= w_addr_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_wr_shift <= w_wr_shift_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign tx_wr_o       = (r_state == S_TX_REQ);
    assign tx_data_o     = r_tx_shift[DATA_W-1 -: 8];
    assign busy_o        = (r_state != S_CMD);
    assign err_o         = r_err;
    assign main_fsm_en_o = regs_o[0];

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_reg_bank
//  Description : Self-checking bench for uart_reg_bank: directed frames plus
//                random WRITE / READ / NOP / junk traffic against an
//                array-based register model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_reg_bank;

    localparam int N_REGS = 4;
    localparam int DATA_W = 16;
    localparam int NB     = DATA_W / 8;

    logic                     clk       = 1'b0;
    logic                     rst_n     = 1'b1;
    logic                     rx_done_i = 1'b0;
    logic [7:0]               data_i    = 8'h00;
    logic                     tx_done_i = 1'b0;
    logic                     tx_wr_o;
    logic [7:0]               tx_data_o;
    logic [N_REGS*DATA_W-1:0] regs_o;
    logic                     main_fsm_en_o;
    logic                     err_o;
    logic                     busy_o;

    uart_reg_bank #(
        .N_REGS (N_REGS),
        .DATA_W (DATA_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_done_i     (rx_done_i),
        .data_i        (data_i),
        .tx_done_i     (tx_done_i),
        .tx_wr_o       (tx_wr_o),
        .tx_data_o     (tx_data_o),
        .regs_o        (regs_o),
        .main_fsm_en_o (main_fsm_en_o),
        .err_o         (err_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          err_seen    = 0;
    int unsigned mregs [N_REGS];

    // Count error pulses, one per high cycle.
    always @(negedge clk) begin
        if (err_o) err_seen++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_flat();
        logic [63:0] f;
        f = '0;
        for (int k = 0; k < N_REGS; k++) f[k*DATA_W +: DATA_W] = DATA_W'(mregs[k]);
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_done_i = 1'b1;
        data_i    = b;
        tick();
        rx_done_i = 1'b0;
        data_i    = 8'h00;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [15:0] data);
        int e0;
        e0 = err_seen;
        rx_byte(8'h01);
        rx_byte(addr);
        rx_byte(data[15:8]);
        rx_byte(data[7:0]);
        if (int'(addr) < N_REGS) mregs[addr] = data;
        @(negedge clk);
        check_val("wr_regs", regs_o, model_flat());
        check_val("wr_en", main_fsm_en_o, 64'(mregs[0] & 1));
        check_val("wr_busy", busy_o, 0);
        tick();
        @(negedge clk);
        check_val("wr_err_cnt", err_seen - e0, (int'(addr) < N_REGS) ? 0 : 1);
        tick();
    endtask

    task automatic do_read(input logic [7:0] addr, input bit inject);
        int          e0;
        int          n_inj;
        int unsigned word;
        logic [7:0]  exp_b;
        e0    = err_seen;
        n_inj = 0;
        word  = (int'(addr) < N_REGS) ? mregs[addr] : 0;
        rx_byte(8'h02);
        rx_byte(addr);
        for (int i = 0; i < NB; i++) begin
            exp_b = 8'((word >> (8 * (NB - 1 - i))) & 32'hFF);
            @(negedge clk);
            check_val("rd_tx_wr", tx_wr_o, 1);
            check_val("rd_tx_data", tx_data_o, exp_b);
            tick();
            @(negedge clk);
            check_val("rd_tx_wr_pulse", tx_wr_o, 0);
            check_val("rd_tx_hold", tx_data_o, exp_b);
            tick();
            repeat ($urandom_range(0, 2)) tick();
            if (inject && i == 0) begin
                rx_byte(8'h99);
                n_inj++;
            end
            tx_done_i = 1'b1;
            tick();
            tx_done_i = 1'b0;
        end
        @(negedge clk);
        check_val("rd_end_busy", busy_o, 0);
        check_val("rd_end_tx_wr", tx_wr_o, 0);
        tick();
        @(negedge clk);
        check_val("rd_err_cnt", err_seen - e0, n_inj + ((int'(addr) < N_REGS) ? 0 : 1));
        check_val("rd_regs", regs_o, model_flat());
        tick();
    endtask

    // Single-byte command that must leave the block idle (NOP or junk).
    task automatic do_cmd(input logic [7:0] b);
        int e0;
        e0 = err_seen;
        rx_byte(b);
        @(negedge clk);
        check_val("cmd_busy", busy_o, 0);
        tick();
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        @(negedge clk);
        check_val("cmd_tx_wr", tx_wr_o, 0);
        check_val("cmd_busy2", busy_o, 0);
        check_val("cmd_err_cnt", err_seen - e0, (b > 8'h02) ? 1 : 0);
        tick();
    endtask

    initial begin
        for (int k = 0; k < N_REGS; k++) mregs[k] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_regs", regs_o, 0);
        check_val("rst_tx_wr", tx_wr_o, 0);
        check_val("rst_tx_data", tx_data_o, 0);
        check_val("rst_err", err_o, 0);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_en", main_fsm_en_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        tick();

        do_write(8'h00, 16'h0001);
        do_write(8'h03, 16'hABCD);
        do_read(8'h03, 1'b0);
        do_write(8'h07, 16'h1234);
        do_read(8'h07, 1'b0);
        do_cmd(8'h5A);
        do_cmd(8'h00);
        do_write(8'h01, 16'h5AA5);
        do_read(8'h01, 1'b1);

        // Reset in the middle of a WRITE frame.
        rx_byte(8'h01);
        rx_byte(8'h02);
        rx_byte(8'h11);
        rst_n = 1'b1;
        tick();
        tick();
        for (int k = 0; k < N_REGS; k++) mregs[k] = 0;
        @(negedge clk);
        check_val("midrst_regs", regs_o, model_flat());
        check_val("midrst_busy", busy_o, 0);
        rst_n = 1'b0;
        tick();
        do_write(8'h02, 16'h2233);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: do_write(8'($urandom_range(0, 7)), 16'($urandom));
                1: do_read(8'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                2: do_cmd(8'($urandom_range(3, 255)));
                default: do_cmd(8'h00);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_reg_bank.md
# uart_reg_bank

Parametrised register bank driven by a UART byte stream. It decodes NOP, WRITE and READ command frames from the UART receiver and holds N_REGS registers of DATA_W bits, exported to the datapath as a flat vector. READ frames return the addressed register to the UART transmitter byte by byte, with a tx_wr_o/tx_done_i handshake. It sits between the UART rx/tx pair and the waveform generator's main FSM, and drives main_fsm_en_o from register 0 bit 0.

## Interface
- N_REGS, 4, number of registers; legal range 1..256.
- DATA_W, 16, register width; must be a multiple of 8 in the range 8..32. NB = DATA_W/8 bytes per register.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high (asserted when rst_n = 1).
- rx_done_i  in  1  one-cycle pulse; data_i holds a valid received byte in that cycle.
- data_i  in  8  received byte.
- tx_done_i  in  1  one-cycle pulse; the transmitter has finished the current byte.
- tx_wr_o  out  1  one-cycle request to send tx_data_o.
- tx_data_o  out  8  byte to transmit; held stable from tx_wr_o until tx_done_i.
- regs_o  out  N_REGS*DATA_W  register contents; register k occupies bits [k*DATA_W +: DATA_W].
- main_fsm_en_o  out  1  register 0 bit 0.
- err_o  out  1  one-cycle pulse on a protocol error.
- busy_o  out  1  high in any state other than S_CMD.

## Operation
- Frame formats (bytes arrive MSB-first):
  - WRITE: 0x01, addr, NB data bytes.
  - READ: 0x02, addr; the block replies with NB bytes, MSB first.
  - NOP: 0x00.
- States:
  - S_CMD
    - On rx_done_i with 0x01: go to S_ADDR, set wr flag.
    - On rx_done_i with 0x02: go to S_ADDR, clear wr flag.
    - On 0x00: stay in S_CMD.
    - On any other byte: stay in S_CMD and pulse err_o.
  - S_ADDR
    - On rx_done_i: latch addr.
    - If wr flag is set: go to S_WDATA with byte_cnt = 0.
    - Otherwise: load tx_shift with register[addr], or 0 if addr >= N_REGS, and go to S_TX_REQ.
  - S_WDATA
    - On rx_done_i: shift data_i into wr_shift and increment byte_cnt.
    - On byte NB-1: commit to register[addr] and go to S_CMD.
  - S_TX_REQ: assert tx_wr_o for exactly one cycle with tx_data_o = tx_shift[DATA_W-1 -: 8], then go to S_TX_WAIT.
  - S_TX_WAIT
    - On tx_done_i at the last byte: go to S_CMD.
    - On tx_done_i otherwise: shift tx_shift left by 8, increment byte_cnt, go to S_TX_REQ.
- Out-of-range address:
  - WRITE: the data bytes are consumed, no register changes, and err_o pulses on the commit cycle.
  - READ: returns NB bytes of 0x00, and err_o pulses when the address is latched.
- rx_done_i during S_TX_REQ or S_TX_WAIT: the byte is dropped and err_o pulses. The read reply is not disturbed.
- tx_done_i outside S_TX_WAIT is ignored.
- Reset values: all registers 0, state S_CMD, tx_wr_o = 0, tx_data_o = 0x00, err_o = 0, busy_o = 0, main_fsm_en_o = 0.
- Reset asserted mid-frame aborts the frame. Partial write data is discarded and no register changes.

## Timing
- Write commit happens on the clock edge that samples the last data byte's rx_done_i. regs_o shows the new value in the following cycle.
- Read: tx_wr_o rises in the cycle after the edge that samples the address byte's rx_done_i. There is 1 cycle of latency between each tx_done_i and the next tx_wr_o.
- The read snapshot is taken at address latch. A later write cannot race it, because rx is ignored while transmitting.
- byte_cnt is $clog2(NB+1) bits wide and wraps only through a state exit.
- When NB = 1, S_WDATA commits on its first byte.
- An 8-bit address with N_REGS = 256 has no out-of-range case.

## Structure
- Package uart_reg_pkg holds:
  - the command constants CMD_NOP = 8'h00, CMD_WR = 8'h01, CMD_RD = 8'h02;
  - state_t {S_CMD, S_ADDR, S_WDATA, S_TX_REQ, S_TX_WAIT}.
- Sub-module reg_bank_core holds the register array, with a write port (we, addr, wdata) and an asynchronous read port.
  - It owns the out-of-range gating.
  - It owns the regs_o flattening.
- The top level holds the frame FSM, the shift registers and the tx handshake.

## Test plan
All scenarios run with N_REGS = 4 and DATA_W = 16.
- WRITE 01 00 00 01 -> regs_o[15:0] = 0x0001 and main_fsm_en_o = 1, both one cycle after the last rx_done_i.
- WRITE 01 03 AB CD, then READ 02 03 -> regs_o[63:48] = 0xABCD; tx_wr_o pulses twice with tx_data_o 0xAB then 0xCD, each pulse 1 cycle after tx_done_i.
- WRITE 01 07 12 34 -> regs_o unchanged and err_o pulses once. READ 02 07 -> returns 0x00, 0x00.
- Command byte 0x5A -> err_o pulses, state stays S_CMD, busy_o = 0. Then NOP 00 -> no error and no state change.
- READ 02 01 with an rx byte 0x99 injected during S_TX_WAIT -> err_o pulses, 2 bytes are still sent correctly, and register 1 is unchanged.
- Reset (rst_n = 1) after 01 02 11 -> register 2 stays 0; after release, 01 02 22 33 writes 0x2233.
